// File: rtl/osr_pull_ctrl.sv
// Output-shift-register pull controller: decides when the OSR loads from the TX FIFO
// (explicit PULL or autopull on OUT/background) and stalls the core on an empty FIFO.
module osr_pull_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        penable,
    input  logic        restart,
    input  logic        exec_out,
    input  logic        exec_pull,
    input  logic        pull_block,
    input  logic        pull_ifempty,
    input  logic        auto_pull,
    input  logic [4:0]  pull_thresh,
    input  logic [5:0]  shift_count,
    input  logic        fifo_empty,
    output logic        osr_set,
    output logic        osr_do_shift,
    output logic        osr_src_x,
    output logic        fifo_pop,
    output logic        stall,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_OUT, WAIT_PULL} state_t;

    state_t      state_q, state_d;
    logic        post_rst_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [5:0]  thr;
    logic        exhausted;
    logic        active;

    assign thr       = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
    assign exhausted = (shift_count >= thr);
    // The cycle after reset is kept quiet as well, so nothing fires until the core has settled.
    assign active    = penable && !reset && !restart && !post_rst_q;

    always_comb begin
        osr_set      = 1'b0;
        osr_do_shift = 1'b0;
        osr_src_x    = 1'b0;
        fifo_pop     = 1'b0;
        stall        = 1'b0;
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        if (active) begin
            case (state_q)
                IDLE: begin
                    if (exec_pull) begin
                        if (pull_ifempty && !exhausted) begin
                            // conditional PULL below threshold does nothing
                        end else if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            osr_set  = 1'b1;
                        end else if (pull_block) begin
                            stall   = 1'b1;
                            state_d = WAIT_PULL;
                        end else begin
                            osr_set   = 1'b1;
                            osr_src_x = 1'b1;
                        end
                    end else if (exec_out) begin
                        if (!auto_pull || !exhausted) begin
                            osr_do_shift = 1'b1;
                        end else if (!fifo_empty) begin
                            fifo_pop     = 1'b1;
                            osr_set      = 1'b1;
                            osr_do_shift = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = WAIT_OUT;
                        end
                    end else if (auto_pull && exhausted && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        osr_set  = 1'b1;
                    end
                end
                WAIT_OUT: begin
                    if (fifo_empty) begin
                        stall = 1'b1;
                    end else begin
                        fifo_pop     = 1'b1;
                        osr_set      = 1'b1;
                        osr_do_shift = 1'b1;
                        state_d      = IDLE;
                    end
                end
                WAIT_PULL: begin
                    if (fifo_empty) begin
                        stall = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        osr_set  = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stall_cnt_q <= 16'd0;
            post_rst_q  <= 1'b1;
        end else begin
            post_rst_q  <= 1'b0;
            state_q     <= restart ? IDLE : state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: doc/osr_pull_ctrl.md
OSR_PULL_CTRL -- requirements
Module: osr_pull_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, single clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset input 1, synchronous active-high; clears all state.
REQ-003 SHALL have ports: penable input 1, state-machine clock enable; 0 freezes state and forces all strobes low.
REQ-004 SHALL have ports: restart input 1, synchronous state-machine restart; returns FSM to IDLE, keeps stall_cnt.
REQ-005 SHALL have ports: exec_out input 1, OUT instruction executing this cycle.
REQ-006 SHALL have ports: exec_pull input 1, PULL instruction executing this cycle.
REQ-007 SHALL have ports: pull_block input 1, PULL blocking flag.
REQ-008 SHALL have ports: pull_ifempty input 1, PULL only if threshold reached.
REQ-009 SHALL have ports: auto_pull input 1, autopull enable.
REQ-010 SHALL have ports: pull_thresh input 5, autopull threshold; 0 means 32.
REQ-011 SHALL have ports: shift_count input 6, OSR bits consumed, 0..32.
REQ-012 SHALL have ports: fifo_empty input 1, TX FIFO empty.
REQ-013 SHALL have ports: osr_set output 1, load OSR.
REQ-014 SHALL have ports: osr_do_shift output 1, shift OSR.
REQ-015 SHALL have ports: osr_src_x output 1, load source is X register, not FIFO.
REQ-016 SHALL have ports: fifo_pop output 1, pop one TX FIFO word.
REQ-017 SHALL have ports: stall output 1, core must hold current instruction.
REQ-018 SHALL have ports: stall_cnt output 16, saturating count of stalled cycles.

Function
REQ-019 SHALL compute thr = (pull_thresh==0) ? 32 : pull_thresh, at 6 bits wide.
REQ-020 SHALL compute exhausted = (shift_count >= thr), as an unsigned 6-bit compare.
REQ-021 SHALL implement an FSM with states IDLE, WAIT_OUT and WAIT_PULL, entered from IDLE only.
REQ-022 SHALL give exec_pull priority over exec_out when both are high in IDLE; exec_out is then ignored.
REQ-023 SHALL handle OUT in IDLE with auto_pull=0 as: osr_do_shift=1, no stall.
REQ-024 SHALL handle OUT in IDLE with auto_pull=1 and !exhausted as: osr_do_shift=1 only.
REQ-025 SHALL handle OUT in IDLE with auto_pull=1, exhausted and !fifo_empty as: fifo_pop=1, osr_set=1, osr_do_shift=1 in the same cycle (load-and-shift).
REQ-026 SHALL handle OUT in IDLE with auto_pull=1, exhausted and fifo_empty as: stall=1, next state WAIT_OUT, no strobes.
REQ-027 SHALL handle PULL in IDLE with pull_ifempty=1 and !exhausted as a no-op: no strobes, no stall.
REQ-028 SHALL handle any other PULL in IDLE with !fifo_empty as: fifo_pop=1, osr_set=1.
REQ-029 SHALL handle PULL in IDLE with fifo_empty and pull_block=1 as: stall=1, next state WAIT_PULL.
REQ-030 SHALL handle PULL in IDLE with fifo_empty and pull_block=0 as: osr_set=1, osr_src_x=1, no pop, no stall.
REQ-031 SHALL, in WAIT_OUT or WAIT_PULL with fifo_empty=1, assert stall=1 and hold the state.
REQ-032 SHALL, in WAIT_OUT with fifo_empty=0, issue fifo_pop, osr_set and osr_do_shift, with stall=0, and return to IDLE.
REQ-033 SHALL, in WAIT_PULL with fifo_empty=0, issue fifo_pop and osr_set, with stall=0, and return to IDLE.
REQ-034 SHALL rely on the core holding exec_* inputs stable while stall=1; wait-state outputs SHALL ignore exec_*.
REQ-035 SHALL perform background autopull: IDLE, no exec_*, auto_pull=1, exhausted and !fifo_empty -> fifo_pop=1, osr_set=1.
REQ-036 SHALL derive all strobes combinationally from state and inputs, gated by penable.
REQ-037 SHALL issue at most one fifo_pop per enabled cycle.
REQ-038 SHALL increment stall_cnt each enabled cycle with stall=1, saturating at 0xFFFF without wrap.
REQ-039 SHALL give restart priority over FSM transitions; strobes SHALL be 0 in a restart cycle.

Reset
REQ-040 SHALL, on reset, set state=IDLE and stall_cnt=0; all outputs SHALL read 0 in the reset cycle and the cycle after.
REQ-041 SHALL, on reset mid-stall (any WAIT state), return to IDLE next cycle with stall=0 and no pop.
REQ-042 SHALL give reset priority over restart and penable.

Verification
REQ-043 SHALL cover: auto_pull=1, thr=32, shift_count=32, fifo_empty=0, exec_out -> same-cycle fifo_pop=osr_set=osr_do_shift=1, stall=0.
REQ-044 SHALL cover: blocking PULL, fifo_empty=1 for 3 cycles then 0 -> stall=1 for 3 cycles, pop+set on the 4th, stall_cnt=3, state back to IDLE.
REQ-045 SHALL cover: non-blocking PULL, fifo_empty=1 -> osr_set=1, osr_src_x=1, fifo_pop=0, stall=0.
REQ-046 SHALL cover: pull_ifempty=1, pull_thresh=8, shift_count=4, exec_pull -> no strobes; with shift_count=8 -> pop+set.
REQ-047 SHALL cover: WAIT_OUT with penable=0 for 2 cycles -> no strobes, stall_cnt unchanged; then restart -> IDLE, stall_cnt retained.
REQ-048 SHALL cover: stall_cnt preset near 0xFFFE, 3 stalled cycles -> reads 0xFFFF, no wrap.
